// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings and FSM state type for the data-memory responder.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/load_align.sv
// Load result formatting: picks the byte/half lane from a memory word and sign- or zero-extends it.
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    // Halves use addr_lo[1] only, so an odd half address lands on its aligned lane.
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];

    case (func3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_W:    data = word;
      F3_BU:   data = {24'd0, lane_b};
      F3_HU:   data = {16'd0, lane_h};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder with configurable wait states.
// Define MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] mem [DEPTH_WORDS];

  state_t          state_reg;
  logic [3:0]      wait_cnt_reg;
  logic [AW+1:0]   addr_reg;
  logic            we_reg;
  logic [2:0]      func3_reg;
  logic [31:0]     wdata_reg;

  logic            unused_addr_hi;
  logic [AW-1:0]   idx;
  logic [31:0]     rd_word;
  logic [31:0]     ld_data;
  logic            f3_ok;
  logic            misalign;
  logic            acc_err;
  logic [BE_W-1:0] be;
  logic [31:0]     wdata_rep;
  logic            mem_we;

  // Address bits above the array wrap away.
  assign unused_addr_hi = ^req_addr[31:AW+2];
  assign idx            = addr_reg[AW+1:2];
  assign rd_word        = mem[idx];

  load_align u_load_align (
    .word    (rd_word),
    .addr_lo (addr_reg[1:0]),
    .func3   (func3_reg),
    .data    (ld_data)
  );

  always_comb begin
    if (we_reg)
      f3_ok = func3_reg inside {F3_B, F3_H, F3_W};
    else
      f3_ok = func3_reg inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};

    misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (func3_reg)
      F3_H, F3_HU: misalign = addr_reg[0];
      F3_W:        misalign = |addr_reg[1:0];
      default:     misalign = 1'b0;
    endcase
`endif
    acc_err = !f3_ok || misalign;
  end

  always_comb begin
    be        = '0;
    wdata_rep = wdata_reg;
    case (func3_reg)
      F3_B: begin
        be        = 4'b0001 << addr_reg[1:0];
        wdata_rep = {4{wdata_reg[7:0]}};
      end
      F3_H: begin
        be        = addr_reg[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_reg[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = '0;
    endcase
  end

  // A store caught by reset in its ACCESS cycle must not land.
  assign mem_we = (state_reg == ACCESS) && we_reg && !acc_err && rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            addr_reg  <= req_addr[AW+1:0];
            we_reg    <= req_we;
            func3_reg <= req_func3;
            wdata_reg <= req_wdata;
            req_ready <= 1'b0;
            if (WAIT_STATES > 0) begin
              state_reg    <= WAIT;
              wait_cnt_reg <= WAIT_LOAD;
            end else begin
              state_reg <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 4'd0)
            state_reg <= ACCESS;
          else
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
        end
        ACCESS: begin
          rsp_rdata <= (acc_err || we_reg) ? 32'd0 : ld_data;
          rsp_err   <= acc_err;
          rsp_valid <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It accepts load/store requests over a valid/ready handshake and executes them against an internal word-organised array. Each access has a configurable number of wait states, and results come back on a separate valid/ready response channel. It serves the same func3 load/store encoding the datapath issues, and replaces the zero-latency data memory when the core is moved to a handshaked bus.

## Interface
Parameters:
- DEPTH_WORDS, 1024: array size in 32-bit words; power of two.
- WAIT_STATES, 1: extra access cycles, 0..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3 size/sign code.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  illegal func3 or misaligned access.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE
  - req_ready=1.
  - On req_valid&&req_ready, capture addr/we/func3/wdata.
  - Go to WAIT if WAIT_STATES>0, else ACCESS.
- WAIT
  - Counter loads WAIT_STATES-1 and decrements.
  - At 0, go to ACCESS.
- ACCESS
  - Single cycle; performs the array read or byte-enabled write.
  - Registers rsp_rdata and rsp_err, then goes to RESP.
- RESP
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE.
- req_ready is 0 in every state except IDLE. Requests presented then are ignored and not queued.
- Word index is req_addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Loads:
  - LB(0) and LH(1) sign-extend; LBU(4) and LHU(5) zero-extend; LW(2) returns the full word.
  - Lane select: addr[1:0] for bytes, addr[1] for halves.
- Stores:
  - SB(0) writes one byte lane, SH(1) two lanes, SW(2) all four.
  - Data comes from wdata[7:0], [15:0] or [31:0], replicated into the selected lanes.
- Illegal func3: loads with 3/6/7 and stores with 3..7 give rsp_err=1, rsp_rdata=0, and no array write.
- Array contents are not reset.

## Timing
- Request accepted in cycle N → rsp_valid first high in cycle N+2+WAIT_STATES.
- Store commits at the clock edge ending ACCESS.
- Response handshake in cycle M → IDLE in M+1; the next request can be accepted in M+1.
- Maximum throughput is one transaction per 3+WAIT_STATES cycles.
- Reset values: req_ready=0 while rst=0 and 1 in the first cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM in IDLE; wait counter 0.
- Reset mid-operation:
  - The transaction is dropped and no response is issued.
  - A store whose ACCESS cycle coincides with rst=0 does not commit.
- rsp_ready low: RESP holds indefinitely with outputs frozen.
- rsp_ready may be high before rsp_valid; the handshake completes in the first RESP cycle.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Misaligned accesses (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) produce rsp_err=1 and rsp_rdata=0.
  - No write is performed.
  - Latency is unchanged.
- MISALIGN_TRAP_EN undefined:
  - Low address bits are forced to alignment (addr[0] cleared for halves, addr[1:0] for words) and the access proceeds.
  - rsp_err flags illegal func3 only.

## Structure
- Shared package riscv_mem_pkg holds:
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the FSM state enum;
  - a byte-enable width constant.
- One sub-module, load_align: combinational lane select plus sign/zero extension from word and func3. The store lane/byte-enable logic stays inline.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → rdata 0xDEADBEEF, err 0; rsp_valid at N+2+WAIT_STATES for WAIT_STATES=0 and 3.
- SB 0x80 @0x13, then:
  - LB @0x13 → 0xFFFFFF80;
  - LBU @0x13 → 0x00000080;
  - LW @0x10 → 0x80ADBEEF.
- SH 0x1234 @0x11:
  - with MISALIGN_TRAP_EN → err 1, LW @0x10 unchanged;
  - without it → LW @0x10 = 0x80AD1234.
- rsp_ready held low 5 cycles → rsp_valid, rdata and err stable, req_ready 0; a req_valid pulse in that window is not accepted.
- rst low during WAIT of SW 0xFFFFFFFF @0x20 → LW @0x20 afterwards returns the old value; outputs at reset values the cycle after rst=0.
- Load with func3=3 → err 1, rdata 0; LW @(4*DEPTH_WORDS+0x10) → same data as @0x10.
